scaler_v: RTL

Vertical linear-interpolation scaler. It sits directly downstream of scaler_h and consumes its pixel stream (di/de/hs/vs).
- Buffers input lines in three rotating line RAMs.
- For each output line, emits the blend of two adjacent input lines, weighted by a fixed-point vertical position accumulator.
- Output uses the same stream format, so it feeds the monitor / next stage unchanged.

---
 rtl/scaler_v.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/scaler_v.sv
// Vertical linear-interpolation scaler: buffers input lines in three rotating
// line RAMs and emits blends of adjacent lines driven by a fixed-point position.
module scaler_v #(
    parameter int PIXEL_STEP  = 128,
    parameter int PIXEL_WIDTH = 8,
    parameter int MAX_LINE    = 4096,
    parameter int STEP_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STEP_WIDTH-1:0]  scale_step,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   err_o
);
    localparam int FW    = $clog2(PIXEL_STEP);
    localparam int AW    = $clog2(MAX_LINE);
    localparam int CW    = AW + 1;
    localparam int POS_W = 32;
    localparam int LW    = POS_W - FW;
    localparam int PW    = PIXEL_WIDTH;
    localparam int MW    = PW + FW + 1;
    localparam int SW    = MW + 1;

    typedef enum logic [2:0] {IDLE, LINE0, WAIT, EMIT_HS, EMIT_DATA, EMIT_GAP} state_t;

    function automatic logic [1:0] prev_bank(input logic [1:0] s);
        return (s == 2'd0) ? 2'd2 : s - 2'd1;
    endfunction

    state_t            state;
    logic              active;
    logic [1:0]        wsel;
    logic [CW-1:0]     wp;
    logic [CW-1:0]     width;
    logic [LW-1:0]     line_idx;
    logic [POS_W-1:0]  pos;
    logic [STEP_WIDTH-1:0] step_r;
    logic [FW-1:0]     f_r;
    logic [1:0]        rsel_a, rsel_b, pend_a, pend_b;
    logic [LW-1:0]     cur_n, pend_n;
    logic              pend, first_r, gap_cnt;
    logic [CW-1:0]     rcnt;
    logic [AW-1:0]     raddr;
    logic              v1, v2, v3;
    logic [MW-1:0]     p_a, p_b;
    logic [SW-1:0]     sum;

    logic              wr_s, lc_s, ovr_s, take_s;
    logic [CW-1:0]     lim_s;
    logic [LW-1:0]     pos_int;
    logic [PW-1:0]     a_s, b_s;
    logic [FW:0]       wa_s;

    always_comb begin
        lim_s   = (line_idx == '0) ? CW'(MAX_LINE) : width;
        wr_s    = active && de_i && !hs_i && (wp < lim_s);
        lc_s    = wr_s && (line_idx != '0) && (wp == width - CW'(1));
        ovr_s   = lc_s && (state == EMIT_HS || state == EMIT_DATA || state == EMIT_GAP);
        take_s  = (state == EMIT_GAP) && gap_cnt;
        pos_int = pos[POS_W-1:FW];
        raddr   = rcnt[AW-1:0];
        wa_s    = (FW+1)'(PIXEL_STEP) - {1'b0, f_r};
    end

    // Input bookkeeping: pixel pointer, line index, bank rotation, latched width
    always_ff @(posedge clk) begin
        if (rst) begin
            active   <= 1'b0;
            wsel     <= 2'd0;
            wp       <= '0;
            line_idx <= '0;
            width    <= '0;
        end else if (vs_i) begin
            active   <= 1'b1;
            wsel     <= 2'd0;
            wp       <= '0;
            line_idx <= '0;
        end else if (active && hs_i) begin
            wp       <= '0;
            line_idx <= line_idx + LW'(1);
            wsel     <= (wsel == 2'd2) ? 2'd0 : wsel + 2'd1;
            if (line_idx == '0) width <= wp;
        end else if (wr_s) begin
            wp <= wp + CW'(1);
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_bank
        logic [PW-1:0] mem [MAX_LINE];
        logic [PW-1:0] q;
        // Line RAM bank: written by the input side, read by the emitter
        always_ff @(posedge clk) begin
            if (wr_s && wsel == 2'(g)) mem[wp[AW-1:0]] <= di_i;
            q <= mem[raddr];
        end
    end

    always_comb begin
        case (rsel_a)
            2'd0:    a_s = g_bank[0].q;
            2'd1:    a_s = g_bank[1].q;
            2'd2:    a_s = g_bank[2].q;
            default: a_s = '0;
        endcase
        case (rsel_b)
            2'd0:    b_s = g_bank[0].q;
            2'd1:    b_s = g_bank[1].q;
            2'd2:    b_s = g_bank[2].q;
            default: b_s = '0;
        endcase
    end

    // Blend pipeline: weighted products, rounded sum, output register
    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            p_a  <= '0;
            p_b  <= '0;
            sum  <= '0;
            do_o <= '0;
            de_o <= 1'b0;
        end else begin
            v1   <= (state == EMIT_DATA) && !vs_i;
            v2   <= v1 && !vs_i;
            v3   <= v2 && !vs_i;
            de_o <= v3 && !vs_i;
            p_a  <= MW'(a_s) * MW'(wa_s);
            p_b  <= MW'(b_s) * MW'(f_r);
            sum  <= SW'(p_a) + SW'(p_b) + SW'(PIXEL_STEP / 2);
            do_o <= v3 ? sum[FW +: PW] : '0;
        end
    end

    // Emission sequencing: position accumulator, overrun recovery, line framing
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pos     <= '0;
            step_r  <= '0;
            f_r     <= '0;
            rsel_a  <= 2'd0;
            rsel_b  <= 2'd0;
            pend_a  <= 2'd0;
            pend_b  <= 2'd0;
            cur_n   <= '0;
            pend_n  <= '0;
            pend    <= 1'b0;
            first_r <= 1'b0;
            gap_cnt <= 1'b0;
            rcnt    <= '0;
            hs_o    <= 1'b0;
            vs_o    <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            hs_o  <= 1'b0;
            vs_o  <= 1'b0;
            err_o <= 1'b0;
            if (vs_i) begin
                pos     <= '0;
                step_r  <= scale_step;
                first_r <= 1'b1;
                pend    <= 1'b0;
                rcnt    <= '0;
                if (scale_step == '0) begin
                    err_o <= 1'b1;
                    state <= IDLE;
                end else begin
                    state <= LINE0;
                end
            end else begin
                // A newer line finished mid-emission: skip ahead to its interval
                if (ovr_s) begin
                    err_o <= 1'b1;
                    pos   <= {line_idx - LW'(1), {FW{1'b0}}};
                    if (!take_s) begin
                        pend   <= 1'b1;
                        pend_n <= line_idx;
                        pend_a <= prev_bank(wsel);
                        pend_b <= wsel;
                    end
                end
                case (state)
                    IDLE: state <= IDLE;
                    LINE0: begin
                        if (hs_i) state <= WAIT;
                    end
                    WAIT: begin
                        if (lc_s && pos_int == line_idx - LW'(1)) begin
                            state  <= EMIT_HS;
                            cur_n  <= line_idx;
                            rsel_a <= prev_bank(wsel);
                            rsel_b <= wsel;
                        end
                    end
                    EMIT_HS: begin
                        hs_o    <= 1'b1;
                        vs_o    <= first_r;
                        first_r <= 1'b0;
                        f_r     <= pos[FW-1:0];
                        if (!ovr_s) pos <= pos + POS_W'(step_r);
                        rcnt    <= '0;
                        state   <= EMIT_DATA;
                    end
                    EMIT_DATA: begin
                        rcnt <= rcnt + CW'(1);
                        if (rcnt == width - CW'(1)) begin
                            gap_cnt <= 1'b0;
                            state   <= EMIT_GAP;
                        end
                    end
                    EMIT_GAP: begin
                        gap_cnt <= 1'b1;
                        if (gap_cnt) begin
                            if (ovr_s) begin
                                pend   <= 1'b0;
                                cur_n  <= line_idx;
                                rsel_a <= prev_bank(wsel);
                                rsel_b <= wsel;
                                state  <= EMIT_HS;
                            end else if (pend) begin
                                pend   <= 1'b0;
                                cur_n  <= pend_n;
                                rsel_a <= pend_a;
                                rsel_b <= pend_b;
                                state  <= EMIT_HS;
                            end else if (pos_int == cur_n - LW'(1)) begin
                                state <= EMIT_HS;
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
